morph3x3_stream: RTL

Streaming 3x3 binary morphology engine for 1-bit camera/LCD image paths. Pixels enter in raster order over a valid/ready stream. Two internal line buffers, each IMG_W deep, form the 3x3 window. Output is the eroded, dilated or bypassed pixel stream with frame and line markers. It sits between the binarisation stage and the frame-buffer writer, and replaces fixed-size, free-running, handshake-less morphology.

---
 rtl/morph3x3_stream.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/morph3x3_stream.sv
// Streaming 3x3 binary erode/dilate/bypass over a valid/ready raster stream.
// Two IMG_W-deep line buffers plus a 3x3 shift window; output lags input by IMG_W+1 pixels.
module morph3x3_stream #(
   parameter int unsigned IMG_W = 630,
   parameter int unsigned IMG_H = 390,
   parameter int unsigned XW    = 10,
   parameter int unsigned YW    = 9
) (
   input  logic       PixelClk,
   input  logic       nRst,
   input  logic [1:0] mode,
   input  logic [8:0] kmask,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic       s_pixel,
   input  logic       s_sof,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_pixel,
   output logic       m_sof,
   output logic       m_eol,
   output logic       m_eof
);

   localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
   localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

   typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

   state_e        state_q;
   logic          en_q;
   logic [XW-1:0] in_x_q, out_x_q;
   logic [YW-1:0] in_y_q, out_y_q;
   logic [1:0]    mode_q;
   logic [8:0]    kmask_q;
   logic [8:0]    win_q;
   logic          gen_done_q;
   logic          lb1_mem [IMG_W];
   logic          lb2_mem [IMG_W];
   logic          rd1_q, rd2_q;

   logic          slot_free, s_hs, sof_acc, in_step, flush_step, step, emit, res;
   logic [XW-1:0] eff_x, x_next, rd_addr;
   logic [YW-1:0] eff_y;
   logic [8:0]    win_d, tap_ok;
   logic [2:0]    row_ok, col_ok;

   always_comb begin
      slot_free = !m_valid || m_ready;
      unique case (state_q)
         StIdle, StFill: s_ready = en_q;
         StRun:          s_ready = en_q && slot_free;
         default:        s_ready = 1'b0;
      endcase
      s_hs       = s_valid && s_ready;
      sof_acc    = s_hs && s_sof;
      in_step    = s_hs && ((state_q != StIdle) || s_sof);
      // Flush keeps the window marching over virtual positions; missing taps are padded.
      flush_step = (state_q == StFlush) && slot_free && !gen_done_q;
      step       = in_step || flush_step;
      emit       = ((state_q == StRun) && in_step && !sof_acc) || flush_step;

      eff_x   = sof_acc ? '0 : in_x_q;
      eff_y   = sof_acc ? '0 : in_y_q;
      x_next  = (eff_x == XLast) ? '0 : eff_x + 1'b1;
      // Prefetch the next column so the registered RAM read is ready on the next accept.
      rd_addr = step ? x_next : in_x_q;

      win_d = {s_pixel, win_q[8:7], rd1_q, win_q[5:4], rd2_q, win_q[2:1]};

      row_ok = {out_y_q != YLast, 1'b1, out_y_q != '0};
      col_ok = {out_x_q != XLast, 1'b1, out_x_q != '0};
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            tap_ok[r*3+c] = row_ok[r] && col_ok[c];
         end
      end

      unique case (mode_q)
         2'b01:   res = &(~kmask_q | ~tap_ok | win_d);
         2'b10:   res = |(kmask_q & tap_ok & win_d);
         default: res = win_d[4];
      endcase
   end

   always_ff @(posedge PixelClk) begin
      if (step) begin
         lb1_mem[eff_x] <= s_pixel;
         lb2_mem[eff_x] <= rd1_q;
      end
      rd1_q <= lb1_mem[rd_addr];
      rd2_q <= lb2_mem[rd_addr];
   end

   always_ff @(posedge PixelClk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= StIdle;
         en_q       <= 1'b0;
         in_x_q     <= '0;
         in_y_q     <= '0;
         out_x_q    <= '0;
         out_y_q    <= '0;
         mode_q     <= '0;
         kmask_q    <= '0;
         win_q      <= '0;
         gen_done_q <= 1'b0;
         m_valid    <= 1'b0;
         m_pixel    <= 1'b0;
         m_sof      <= 1'b0;
         m_eol      <= 1'b0;
         m_eof      <= 1'b0;
      end else begin
         en_q <= 1'b1;
         if (step) begin
            in_x_q <= x_next;
            win_q  <= win_d;
         end
         if (in_step) in_y_q <= (eff_x == XLast) ? eff_y + 1'b1 : eff_y;

         if (sof_acc) begin
            mode_q     <= mode;
            kmask_q    <= kmask;
            out_x_q    <= '0;
            out_y_q    <= '0;
            gen_done_q <= 1'b0;
         end else if (emit) begin
            if (out_x_q == XLast) begin
               out_x_q <= '0;
               out_y_q <= out_y_q + 1'b1;
               if (out_y_q == YLast) gen_done_q <= 1'b1;
            end else begin
               out_x_q <= out_x_q + 1'b1;
            end
         end

         if (emit) begin
            m_valid <= 1'b1;
            m_pixel <= res;
            m_sof   <= (out_x_q == '0) && (out_y_q == '0);
            m_eol   <= (out_x_q == XLast);
            m_eof   <= (out_x_q == XLast) && (out_y_q == YLast);
         end else if (m_ready) begin
            m_valid <= 1'b0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
         end

         unique case (state_q)
            StIdle:  if (sof_acc) state_q <= StFill;
            StFill:  if (!sof_acc && in_step && in_x_q == '0 && in_y_q == YW'(1))
                        state_q <= StRun;
            StRun:   if (sof_acc) state_q <= StFill;
                     else if (in_step && in_x_q == XLast && in_y_q == YLast)
                        state_q <= StFlush;
            StFlush: if (m_valid && m_ready && m_eof) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
